idli_uart_ctrl_m: RTL
=====================

# idli_uart_ctrl_m

Parametrised, full-duplex UART controller with a nibble-serial (sqi_data_t) core-side interface, independent TX and RX character FIFOs, a configurable character width and bit period, and RX error reporting. It replaces the single-character TX-only UART at the core's top level. The execute stage streams characters in and out one nibble per cycle, least-significant nibble first.

## Interface
- CHAR_W, 8: bits per character; multiple of 4, range 4–16.
- TX_DEPTH, 4: TX FIFO depth in characters; power of 2, ≥2.
- RX_DEPTH, 4: RX FIFO depth in characters; power of 2, ≥2.
- CLK_DIV, 16: clock cycles per bit; even, ≥4.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- i_uart_gck  in  1  clock.
- i_uart_rst  in  1  asynchronous, active-high reset.
- i_uart_tx  in  4  TX nibble.
- i_uart_tx_vld  in  1  TX nibble valid.
- o_uart_tx_acp  out  1  TX nibble accepted; equals !tx_full.
- o_uart_tx_idle  out  1  TX FIFO empty and TX FSM in IDLE.
- o_uart_rx  out  4  RX nibble: head character, current nibble.
- o_uart_rx_vld  out  1  RX FIFO non-empty.
- i_uart_rx_acp  in  1  consumer takes the RX nibble.
- o_uart_rx_ferr  out  1  one-cycle pulse on framing error.
- o_uart_rx_ovf  out  1  sticky overrun flag.
- i_uart_ovf_clr  in  1  clears o_uart_rx_ovf.
- i_uart_rx  in  1  serial line in, asynchronous.
- o_uart_tx  out  1  serial line out, registered.

## Operation
- Nibbles per character: NPC = CHAR_W/4.
- **TX assembly**
  - A handshake (vld & acp) writes the nibble into the assembly register at the current nibble index, then increments the index.
  - On nibble NPC-1 the full character is pushed into the TX FIFO and the index wraps to 0.
  - Once the first nibble is accepted, acp stays high until the character completes, because the FIFO has no other writer.
- **TX FSM: IDLE → START → DATA → STOP → IDLE**
  - IDLE pops the FIFO head when the FIFO is non-empty.
  - START drives 0 for CLK_DIV cycles.
  - DATA drives CHAR_W bits, LSB first, CLK_DIV cycles each.
  - STOP drives 1 for STOP_BITS×CLK_DIV cycles.
  - From STOP, the FSM goes straight to START if the FIFO is non-empty at the end of STOP, giving back-to-back frames with no idle gap.
- **RX path**
  - i_uart_rx passes through a 2-flop synchroniser; both flops reset to 1.
- **RX FSM: IDLE → START → DATA → STOP → IDLE**
  - IDLE moves to START on a synchronised 1→0 transition.
  - START waits CLK_DIV/2 cycles and resamples. If the line is 1, the event is a glitch and the FSM returns to IDLE with nothing reported.
  - DATA then samples every CLK_DIV cycles, CHAR_W times, shifting LSB first.
  - STOP takes one sample after a further CLK_DIV cycles. Only the first stop bit is checked.
  - Stop sample = 0: discard the character, pulse o_uart_rx_ferr, return to IDLE.
  - Stop sample = 1 and RX FIFO not full: push the character.
  - Stop sample = 1 and RX FIFO full: drop the character and set o_uart_rx_ovf.
- **RX drain**
  - o_uart_rx = head[4·idx+3 : 4·idx].
  - Each handshake increments idx. The handshake on nibble NPC-1 pops the FIFO and resets idx to 0.
- **Overrun flag**
  - Set by an overrun, cleared by i_uart_ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- **FIFO rules**
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while full cannot occur on TX (acp is low); on RX it is the overrun case.
  - Pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.

## Timing
- **Reset values** (reset asserted asynchronously, released synchronously to i_uart_gck):
  - o_uart_tx=1, o_uart_tx_acp=1, o_uart_tx_idle=1.
  - o_uart_rx_vld=0, o_uart_rx=0, o_uart_rx_ferr=0, o_uart_rx_ovf=0.
  - FSMs in IDLE, FIFOs empty, nibble indices 0.
- **Reset mid-operation:** frames are aborted, partial characters and all FIFO contents are discarded, and the line returns to 1 immediately.
- **TX latency:** if the final nibble handshake is in cycle t and TX is idle with an empty FIFO, o_uart_tx falls in cycle t+2.
- **Frame length:** (1+CHAR_W+STOP_BITS)×CLK_DIV cycles.
- **RX latency:** o_uart_rx_vld rises 3 cycles after the stop-bit sample point. This is the 2-flop synchroniser delay plus the push.
- **Handshakes:** o_uart_tx_acp and o_uart_rx_vld are combinational from FIFO state only, never from the partner's vld or acp. There are no combinational loops.

## Structure
- **Additions to idli_pkg:**
  - uart_state_t enum {UART_IDLE, UART_START, UART_DATA, UART_STOP}.
  - UART_NIB_W = 4, alias of the sqi_data_t width.
- **Sub-module idli_uart_fifo_m** (parameters WIDTH, DEPTH): synchronous FIFO, instantiated for TX and for RX.
  - Ports: push, pop, data in, head out, full, empty.
- TX and RX FSMs each keep their own bit-period counter and bit counter inside idli_uart_ctrl_m.

## Test plan
All scenarios use CLK_DIV=4, CHAR_W=8, STOP_BITS=1.
- **TX frame:** nibbles 0x5 then 0xA → o_uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total; o_uart_tx_idle returns to 1 afterwards.
- **TX back-pressure:** push 5 characters (0x01–0x05) with TX_DEPTH=4 → acp drops once 4 are queued, 5 frames go out back-to-back with no idle gap, data in order.
- **RX loopback:** drive 0x3C serially → o_uart_rx_vld rises, nibbles 0xC then 0x3 are presented, the FIFO empties after the second handshake.
- **RX errors:**
  - Stop bit driven 0 → o_uart_rx_ferr pulses once, o_uart_rx_vld stays 0.
  - 2-cycle low glitch on the line → no character and no error.
- **Overrun:** 5 characters received with RX_DEPTH=4 and no drain → o_uart_rx_ovf=1, the first 4 characters are intact, the fifth is lost; ovf_clr coinciding with a new overrun → flag stays 1.
- **Reset mid-frame:** assert i_uart_rst during TX DATA → o_uart_tx=1 in the same cycle, o_uart_tx_acp=1, o_uart_tx_idle=1, the queued character is never sent.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared core types: nibble-serial data width and UART frame FSM states.
package idli_pkg;

    localparam int UART_NIB_W = 4;

    typedef logic [UART_NIB_W-1:0] sqi_data_t;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/idli_uart_fifo_m.sv
// Synchronous character FIFO for the UART: power-of-2 depth, naturally wrapping
// pointers, push ignored when full and pop ignored when empty.
module idli_uart_fifo_m #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             gck,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge gck) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge gck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/idli_uart_ctrl_m.sv
// Full-duplex UART controller: nibble-serial core side, TX/RX character FIFOs,
// configurable character width, bit period and stop bits, RX framing/overrun reporting.
module idli_uart_ctrl_m
    import idli_pkg::*;
#(
    parameter int CHAR_W    = 8,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                  i_uart_gck,
    input  logic                  i_uart_rst,
    input  logic [UART_NIB_W-1:0] i_uart_tx,
    input  logic                  i_uart_tx_vld,
    output logic                  o_uart_tx_acp,
    output logic                  o_uart_tx_idle,
    output logic [UART_NIB_W-1:0] o_uart_rx,
    output logic                  o_uart_rx_vld,
    input  logic                  i_uart_rx_acp,
    output logic                  o_uart_rx_ferr,
    output logic                  o_uart_rx_ovf,
    input  logic                  i_uart_ovf_clr,
    input  logic                  i_uart_rx,
    output logic                  o_uart_tx
);
    localparam int NPC      = CHAR_W / UART_NIB_W;
    localparam int NIB_W    = (NPC > 1) ? $clog2(NPC) : 1;
    localparam int BIT_W    = $clog2(CHAR_W);
    localparam int TX_CNT_W = $clog2(STOP_BITS * CLK_DIV);
    localparam int RX_CNT_W = $clog2(CLK_DIV);

    localparam logic [NIB_W-1:0]    NIB_LAST    = NIB_W'(NPC - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(CHAR_W - 1);
    localparam logic [TX_CNT_W-1:0] TX_BIT_END  = TX_CNT_W'(CLK_DIV - 1);
    localparam logic [TX_CNT_W-1:0] TX_STOP_END = TX_CNT_W'(STOP_BITS * CLK_DIV - 1);
    localparam logic [RX_CNT_W-1:0] RX_BIT_END  = RX_CNT_W'(CLK_DIV - 1);
    localparam logic [RX_CNT_W-1:0] RX_HALF_END = RX_CNT_W'(CLK_DIV / 2 - 1);

    logic [NIB_W-1:0]    tx_nib_idx;
    logic [CHAR_W-1:0]   tx_asm, tx_char, tx_head;
    logic                tx_hs, tx_push, tx_pop, tx_full, tx_empty;
    uart_state_t         tx_state, tx_state_n;
    logic [TX_CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0]    tx_bit, tx_bit_n;
    logic [CHAR_W-1:0]   tx_shift, tx_shift_n;
    logic                tx_line, tx_line_n;

    logic                rx_meta, rx_sync, rx_prev;
    uart_state_t         rx_state, rx_state_n;
    logic [RX_CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [BIT_W-1:0]    rx_bit, rx_bit_n;
    logic [CHAR_W-1:0]   rx_shift, rx_shift_n, rx_head;
    logic                rx_push, rx_pop, rx_hs, rx_full, rx_empty;
    logic                rx_ferr_n, ovf_set;
    logic [NIB_W-1:0]    rx_nib_idx;

    idli_uart_fifo_m #(.WIDTH(CHAR_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .gck(i_uart_gck), .rst(i_uart_rst), .push(tx_push), .pop(tx_pop),
        .data(tx_char), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    idli_uart_fifo_m #(.WIDTH(CHAR_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .gck(i_uart_gck), .rst(i_uart_rst), .push(rx_push), .pop(rx_pop),
        .data(rx_shift), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign o_uart_tx_acp  = !tx_full;
    assign o_uart_tx_idle = tx_empty && (tx_state == UART_IDLE);
    assign o_uart_tx      = tx_line;
    assign tx_hs          = i_uart_tx_vld && !tx_full;
    assign tx_push        = tx_hs && (tx_nib_idx == NIB_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        tx_char = tx_asm;
        tx_char[int'(tx_nib_idx)*UART_NIB_W +: UART_NIB_W] = i_uart_tx;
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + TX_CNT_W'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        case (tx_state)
            UART_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_line_n  = 1'b0;
                    tx_state_n = UART_START;
                end
            end
            UART_START: begin
                if (tx_cnt == TX_BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = UART_DATA;
                end
            end
            UART_DATA: begin
                if (tx_cnt == TX_BIT_END) begin
                    tx_cnt_n = '0;
                    if (tx_bit == BIT_LAST) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = UART_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + BIT_W'(1);
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift_n[0];
                    end
                end
            end
            UART_STOP: begin
                if (tx_cnt == TX_STOP_END) begin
                    tx_cnt_n = '0;
                    // A waiting character starts immediately, with no idle bit between frames.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
                        tx_line_n  = 1'b0;
                        tx_state_n = UART_START;
                    end else begin
                        tx_state_n = UART_IDLE;
                    end
                end
            end
            default: tx_state_n = UART_IDLE;
        endcase
    end

    always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
        if (i_uart_rst) begin
            tx_nib_idx <= '0;
            tx_asm     <= '0;
            tx_state   <= UART_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_line    <= 1'b1;
        end else begin
            if (tx_hs) begin
                tx_asm     <= tx_char;
                tx_nib_idx <= tx_push ? '0 : tx_nib_idx + NIB_W'(1);
            end
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    // Synchroniser and edge history reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
        if (i_uart_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + RX_CNT_W'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_ferr_n  = 1'b0;
        ovf_set    = 1'b0;
        case (rx_state)
            UART_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_sync) rx_state_n = UART_START;
            end
            UART_START: begin
                if (rx_cnt == RX_HALF_END) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                if (rx_cnt == RX_BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[CHAR_W-1:1]};
                    if (rx_bit == BIT_LAST) rx_state_n = UART_STOP;
                    else                    rx_bit_n   = rx_bit + BIT_W'(1);
                end
            end
            UART_STOP: begin
                if (rx_cnt == RX_BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_state_n = UART_IDLE;
                    if (!rx_sync)     rx_ferr_n = 1'b1;
                    else if (!rx_full) rx_push  = 1'b1;
                    else               ovf_set  = 1'b1;
                end
            end
            default: rx_state_n = UART_IDLE;
        endcase
    end

    assign rx_hs         = i_uart_rx_acp && !rx_empty;
    assign rx_pop        = rx_hs && (rx_nib_idx == NIB_LAST);
    assign o_uart_rx_vld = !rx_empty;
    assign o_uart_rx     = rx_empty ? '0 : rx_head[int'(rx_nib_idx)*UART_NIB_W +: UART_NIB_W];

    always_ff @(posedge i_uart_gck or posedge i_uart_rst) begin
        if (i_uart_rst) begin
            rx_state       <= UART_IDLE;
            rx_cnt         <= '0;
            rx_bit         <= '0;
            rx_shift       <= '0;
            rx_nib_idx     <= '0;
            o_uart_rx_ferr <= 1'b0;
            o_uart_rx_ovf  <= 1'b0;
        end else begin
            rx_state       <= rx_state_n;
            rx_cnt         <= rx_cnt_n;
            rx_bit         <= rx_bit_n;
            rx_shift       <= rx_shift_n;
            o_uart_rx_ferr <= rx_ferr_n;
            if (rx_hs) rx_nib_idx <= rx_pop ? '0 : rx_nib_idx + NIB_W'(1);
            if (ovf_set)             o_uart_rx_ovf <= 1'b1;
            else if (i_uart_ovf_clr) o_uart_rx_ovf <= 1'b0;
        end
    end

endmodule
